// File: rtl/pipe_writeback_regfile.sv
// Write-back end of the Y86-64 pipelined register file.
// Holds the W pipeline register, retires the instruction in W into a
// 15-entry register array through the E and M write ports, serves the two
// decode read ports, and tracks RUN/HALTED processor status.
module pipe_writeback_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              W_stall,
  input  logic              W_bubble,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [2:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [63:0]       retired
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_HLT    = 3'd2;
  localparam logic [2:0] S_ADR    = 3'd3;
  localparam logic [2:0] S_INS    = 3'd4;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // W pipeline register; w_bub_reg marks an inserted bubble so that a
  // genuine nop (same encoding) can still be counted as retired.
  logic [2:0]        w_stat_reg;
  logic [3:0]        w_icode_reg;
  logic [DATA_W-1:0] w_vale_reg;
  logic [DATA_W-1:0] w_valm_reg;
  logic [3:0]        w_dste_reg;
  logic [3:0]        w_dstm_reg;
  logic              w_bub_reg;

  logic [0:0]        state_reg;
  logic [2:0]        stat_reg;
  logic [63:0]       retired_reg;

  logic [DATA_W-1:0] rf_reg [NREG];

  logic              retire;
  logic              write_en;
  logic              halt_hit;
  logic [2:0]        halt_code;

  // The instruction in W retires on the first unstalled edge while running;
  // stall cycles therefore never repeat its writes or its count.
  assign retire   = (state_reg == ST_RUN) && !W_stall;
  assign write_en = retire && (w_stat_reg == S_AOK);
  assign halt_hit = retire && (w_stat_reg != S_AOK);

  // Any stat code outside HLT/ADR/INS is reported as an invalid instruction.
  always_comb begin
    halt_code = S_INS;
    if (w_stat_reg == S_HLT || w_stat_reg == S_ADR || w_stat_reg == S_INS)
      halt_code = w_stat_reg;
  end

  // W register: bubble beats stall; frozen entirely once halted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_stat_reg  <= S_AOK;
      w_icode_reg <= I_NOP;
      w_vale_reg  <= '0;
      w_valm_reg  <= '0;
      w_dste_reg  <= RNONE;
      w_dstm_reg  <= RNONE;
      w_bub_reg   <= 1'b1;
    end else if (state_reg == ST_RUN) begin
      if (W_bubble) begin
        w_stat_reg  <= S_AOK;
        w_icode_reg <= I_NOP;
        w_vale_reg  <= '0;
        w_valm_reg  <= '0;
        w_dste_reg  <= RNONE;
        w_dstm_reg  <= RNONE;
        w_bub_reg   <= 1'b1;
      end else if (!W_stall) begin
        w_stat_reg  <= m_stat;
        w_icode_reg <= m_icode;
        w_vale_reg  <= m_valE;
        w_valm_reg  <= m_valM;
        w_dste_reg  <= m_dstE;
        w_dstm_reg  <= m_dstM;
        w_bub_reg   <= 1'b0;
      end
    end
  end

  // Register array: one flop bank per entry so reset can load the index.
  // When both ports target the same entry the M port wins (popq %rsp).
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      // Retire-edge update of entry gi from the W register contents.
      always_ff @(posedge clk) begin
        if (!rst_n)
          rf_reg[gi] <= DATA_W'(gi);
        else if (write_en && w_dstm_reg == 4'(gi))
          rf_reg[gi] <= w_valm_reg;
        else if (write_en && w_dste_reg == 4'(gi))
          rf_reg[gi] <= w_vale_reg;
      end
    end
  endgenerate

  // Status machine and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      stat_reg    <= S_AOK;
      retired_reg <= '0;
    end else if (retire) begin
      if (!w_bub_reg)
        retired_reg <= retired_reg + 64'd1;
      if (halt_hit) begin
        state_reg <= ST_HALTED;
        stat_reg  <= halt_code;
      end
    end
  end

  // Decode read ports: plain array reads, RNONE returns zero.
  always_comb begin
    d_rvalA = '0;
    d_rvalB = '0;
    if (srcA != RNONE)
      d_rvalA = rf_reg[srcA];
    if (srcB != RNONE)
      d_rvalB = rf_reg[srcB];
  end

  assign W_stat  = w_stat_reg;
  assign W_icode = w_icode_reg;
  assign W_valE  = w_vale_reg;
  assign W_valM  = w_valm_reg;
  assign W_dstE  = w_dste_reg;
  assign W_dstM  = w_dstm_reg;
  assign stat    = stat_reg;
  assign halted  = (state_reg == ST_HALTED);
  assign retired = retired_reg;

endmodule

// File: tb/tb_pipe_writeback_regfile.sv
// Bench for pipe_writeback_regfile: directed instruction stream, a
// behavioural model of architectural state checked every cycle, plus
// hand-computed literal checks at key points.
module tb_pipe_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        W_stall, W_bubble;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  m_dstE, m_dstM;
  logic [3:0]  srcA, srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] retired;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_writeback_regfile #(.DATA_W(64), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .srcA(srcA), .srcB(srcB),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .stat(stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] mreg [15];
  logic [2:0]  mw_stat;
  logic [3:0]  mw_icode;
  logic [63:0] mw_valE, mw_valM;
  logic [3:0]  mw_dstE, mw_dstM;
  bit          mw_bub;
  bit          mhalt;
  logic [2:0]  mstat;
  logic [63:0] mretired;
  bit          mvalid = 0;

  task automatic model_load_bubble();
    mw_stat = 3'd1; mw_icode = 4'd1; mw_valE = '0; mw_valM = '0;
    mw_dstE = 4'hF; mw_dstM = 4'hF; mw_bub = 1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) mreg[i] = 64'(i);
      model_load_bubble();
      mhalt = 0; mstat = 3'd1; mretired = '0; mvalid = 1;
    end else if (mvalid && !mhalt) begin
      // instruction currently in W leaves the pipe on an unstalled edge
      if (!W_stall) begin
        if (mw_stat == 3'd1) begin
          if (mw_dstE != 4'hF) mreg[mw_dstE] = mw_valE;
          if (mw_dstM != 4'hF) mreg[mw_dstM] = mw_valM;
        end
        if (!mw_bub) mretired = mretired + 1;
        if (mw_stat != 3'd1) begin
          mhalt = 1;
          mstat = (mw_stat >= 3'd2 && mw_stat <= 3'd4) ? mw_stat : 3'd4;
        end
      end
      if (W_bubble) model_load_bubble();
      else if (!W_stall) begin
        mw_stat = m_stat; mw_icode = m_icode; mw_valE = m_valE; mw_valM = m_valM;
        mw_dstE = m_dstE; mw_dstM = m_dstM; mw_bub = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (mvalid) begin
      chk("d_rvalA", d_rvalA, (srcA == 4'hF) ? 64'd0 : mreg[srcA]);
      chk("d_rvalB", d_rvalB, (srcB == 4'hF) ? 64'd0 : mreg[srcB]);
      chk("W_stat",  64'(W_stat),  64'(mw_stat));
      chk("W_icode", 64'(W_icode), 64'(mw_icode));
      chk("W_valE",  W_valE, mw_valE);
      chk("W_valM",  W_valM, mw_valM);
      chk("W_dstE",  64'(W_dstE), 64'(mw_dstE));
      chk("W_dstM",  64'(W_dstM), 64'(mw_dstM));
      chk("stat",    64'(stat), 64'(mhalt ? mstat : 3'd1));
      chk("halted",  64'(halted), 64'(mhalt));
      chk("retired", retired, mretired);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                      input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    m_stat = s; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
    W_bubble = 0; W_stall = 0;
    tick();
    $display("send stat=%0d icode=%h valE=%h valM=%h dstE=%h dstM=%h retired=%0d",
             s, ic, ve, vm, de, dm, retired);
  endtask

  task automatic bub();
    W_bubble = 1; W_stall = 0;
    tick();
    W_bubble = 0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [63:0] exp, input string name);
    srcA = a;
    #1;
    chk(name, d_rvalA, exp);
  endtask

  initial begin
    rst_n = 0; W_stall = 0; W_bubble = 0;
    m_stat = 3'd1; m_icode = 4'd1; m_valE = '0; m_valM = '0;
    m_dstE = 4'hF; m_dstM = 4'hF; srcA = 4'hF; srcB = 4'hF;
    tick(); tick();
    rst_n = 1;

    // reset state: registers hold their index
    W_bubble = 1;
    for (int i = 0; i < 15; i++) begin
      srcA = 4'(i); srcB = 4'(14 - i);
      tick();
      chk("rst_reg", d_rvalA, 64'(i));
    end
    rd(4'hF, 64'd0, "rnone_read");
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retired", retired, 64'd0);
    W_bubble = 0;

    // irmovq into %rdx, then bubbles
    send(3'd1, 4'd3, 64'h1234, 64'd0, 4'd2, 4'hF);
    bub();
    rd(4'd2, 64'h1234, "irmovq_reg2");
    chk("irmovq_retired", retired, 64'd1);
    bub();
    chk("bubble_retired", retired, 64'd1);

    // popq %rsp: M port wins
    send(3'd1, 4'hB, 64'h108, 64'hBEEF, 4'd4, 4'd4);
    bub();
    rd(4'd4, 64'hBEEF, "popq_rsp");
    chk("popq_retired", retired, 64'd2);

    // OPq held in W by a 3-cycle stall
    send(3'd1, 4'd6, 64'd7, 64'd0, 4'd3, 4'hF);
    srcA = 4'd5;
    m_valE = 64'd99; m_dstE = 4'd5; W_stall = 1;
    tick(); tick(); tick();
    chk("stall_retired", retired, 64'd2);
    chk("stall_W_dstE", 64'(W_dstE), 64'd3);
    bub();
    rd(4'd3, 64'd7, "stall_reg3");
    rd(4'd5, 64'd5, "stall_reg5");
    chk("stall_release_retired", retired, 64'd3);

    // genuine nop counts, bubble does not
    send(3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF);
    bub();
    chk("nop_retired", retired, 64'd4);

    // stall and bubble together: bubble is loaded
    m_stat = 3'd1; m_icode = 4'd6; m_valE = 64'h55; m_dstE = 4'd6; m_dstM = 4'hF;
    W_stall = 1; W_bubble = 1;
    tick();
    W_stall = 0; W_bubble = 0;
    chk("sb_W_icode", 64'(W_icode), 64'd1);
    chk("sb_W_dstE", 64'(W_dstE), 64'hF);
    chk("sb_W_valE", W_valE, 64'd0);

    // ADR fault: no write, halt, frozen afterwards
    send(3'd3, 4'd5, 64'hAAAA, 64'd0, 4'd1, 4'hF);
    send(3'd1, 4'd3, 64'h77, 64'd0, 4'd7, 4'hF);
    send(3'd1, 4'd3, 64'h88, 64'd0, 4'd8, 4'hF);
    bub(); bub();
    rd(4'd1, 64'd1, "adr_reg1");
    rd(4'd7, 64'd7, "halt_reg7");
    chk("adr_halted", 64'(halted), 64'd1);
    chk("adr_stat", 64'(stat), 64'd3);
    chk("adr_retired", retired, 64'd5);

    // reset with stall high wins
    W_stall = 1; rst_n = 0;
    tick();
    rst_n = 1; W_stall = 0;
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_stat", 64'(stat), 64'd1);
    chk("rst2_retired", retired, 64'd0);
    chk("rst2_W_icode", 64'(W_icode), 64'd1);
    rd(4'd2, 64'd2, "rst2_reg2");
    rd(4'd4, 64'd4, "rst2_reg4");

    // unknown stat code halts as INS and writes nothing
    send(3'd0, 4'd2, 64'hDEAD, 64'd0, 4'd8, 4'hF);
    bub();
    rd(4'd8, 64'd8, "unk_reg8");
    chk("unk_stat", 64'(stat), 64'd4);
    chk("unk_halted", 64'(halted), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
